fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage of the MIPS core. Sits directly upstream of main_decoder.
- Holds the PC and fetches one word per instruction from instruction memory over a req/ack handshake.
- Latches the word into the instruction register and drives opcode to main_decoder.
- Consumes main_decoder's branch/j outputs and the ALU zero flag to select the next PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  32  fetch byte address (= pc).
imem_ack  input  1  memory has imem_rdata valid this cycle.
imem_rdata  input  32  fetched instruction word.
instr  output  32  instruction register contents.
opcode  output  6  instr[31:26], to main_decoder.opcode.
instr_valid  output  1  instr holds a fetched, not-yet-retired instruction.
stall  input  1  downstream not ready; hold current instruction.
branch  input  1  from main_decoder.
j  input  1  from main_decoder.
zero  input  1  ALU equality flag for the current instruction.
pc  output  32  address of the current instruction.
pc_plus4  output  32  pc + 4, for link/branch use downstream.

Behaviour:
- Clock and reset: single clock domain. rst is asynchronous, active-high. While rst=1:
  - state=S_IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0.
  - opcode=0 and imem_addr=RESET_PC.
- States:
  - S_IDLE: always goes to S_REQ on the next edge. Exists so imem_req never rises in the reset-release cycle.
  - S_REQ: imem_req=1, imem_addr=pc, both stable until ack. On a clk edge with imem_ack=1: instr<=imem_rdata, go to S_VALID. Same-cycle ack (0-wait memory) is legal. Any number of wait cycles is allowed.
  - S_VALID: instr_valid=1, imem_req=0.
    - stall=1: instr and pc held.
    - stall=0: pc<=next_pc, go to S_REQ. One instruction retires per exit from S_VALID.
- Ack handling: imem_ack outside S_REQ is ignored (no register change).
- next_pc priority, evaluated combinationally from the current instr and inputs:
  1. j=1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  2. branch=1 & zero=1: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}).
  3. Otherwise: pc_plus4.
- Arithmetic: all 32-bit modulo 2^32 with no overflow detection. pc=32'hFFFF_FFFC gives pc_plus4=0.
- Alignment: pc[1:0] is always 00; no misalignment handling is needed.
- Output timing: imem_req and instr_valid are decoded from the registered state. opcode is a direct slice of instr.
- Throughput: best case is one instruction per 2 cycles (S_REQ with immediate ack, then S_VALID).
- Reset mid-operation: rst in any state aborts the outstanding fetch immediately. A late ack after reset release, seen in S_IDLE, is ignored.

Optional Feature:
FETCH_PERF_EN
- Defined:
  - Adds output fetch_count [31:0], reset to 0.
  - Increments by 1 on every S_VALID exit (stall=0); wraps at 2^32.
  - Adds output stall_count [31:0], reset to 0.
  - Increments every cycle spent in S_VALID with stall=1, or in S_REQ without ack.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
1. Reset and first fetch (RESET_PC=0): rst high 3 cycles, then release.
   - imem_req=0 during reset and in the first cycle after release, then 1 with imem_addr=0.
   - Ack with 32'h8C01_0004 → instr_valid=1, opcode=6'b100011, pc=0.
   - With stall=0, next imem_addr=4.
2. Wait states and wrap (RESET_PC=32'hFFFF_FFFC): hold ack low 3 cycles.
   - imem_req=1 and imem_addr=32'hFFFF_FFFC stable, instr_valid=0.
   - After ack and retire, the next request is at imem_addr=0.
3. Branch: instr 32'h1000_0003 at pc=8.
   - branch=1, zero=1 → next addr 32'h18.
   - branch=1, zero=0 → 32'hC.
   - instr 32'h1000_FFFF at pc=32'h20, taken → 32'h20.
4. Jump: instr 32'h0800_0010 at pc=32'h1000_0000, j=1 → next addr 32'h1000_0040, even if branch=1 and zero=1.
5. Stall: stall=1 for 5 cycles in S_VALID while imem_ack is pulsed.
   - instr, pc and instr_valid=1 are unchanged; imem_req=0.
   - Release stall → exactly one new request.
6. Async reset mid-fetch: assert rst between edges in S_REQ.
   - imem_req=0, instr_valid=0, pc=RESET_PC immediately, without a clock edge.
   - With FETCH_PERF_EN defined, both counters read 0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch stage of the MIPS core, upstream of main_decoder.
//
// Holds the PC, fetches one word per instruction over a req/ack handshake,
// latches it into the instruction register and selects the next PC from
// main_decoder's branch/j and the ALU zero flag when the instruction retires.
//
// Parameters:
//   RESET_PC     PC loaded on reset (word-aligned).
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   imem_req     fetch request (high in S_REQ only)
//   imem_addr    fetch byte address (= pc)
//   imem_ack     imem_rdata valid this cycle (only honoured in S_REQ)
//   imem_rdata   fetched instruction word
//   instr        instruction register
//   opcode       instr[31:26], to main_decoder
//   instr_valid  instr holds a fetched, not-yet-retired instruction
//   stall        downstream not ready; hold current instruction
//   branch, j    control from main_decoder
//   zero         ALU equality flag for the current instruction
//   pc, pc_plus4 current instruction address and its successor
// Optional build macro:
//   FETCH_PERF_EN  adds fetch_count (retired instructions) and stall_count
//                  (cycles stalled in S_VALID or waiting for ack in S_REQ).

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        branch,
  input  logic        j,
  input  logic        zero,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_VALID} state_t;

  state_t      r_state, w_next_state;
  logic [31:0] r_pc, r_instr;
  logic [31:0] w_pc_plus4, w_br_off, w_next_pc;
  logic        w_load, w_retire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // S_IDLE is a one-cycle buffer so imem_req never rises in the cycle reset
  // is released; a stale ack arriving there is simply ignored.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_retire     = 1'b0;
    imem_req     = 1'b0;
    instr_valid  = 1'b0;
    case (r_state)
      S_IDLE:  w_next_state = S_REQ;
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          w_load       = 1'b1;
          w_next_state = S_VALID;
        end
      end
      S_VALID: begin
        instr_valid = 1'b1;
        if (!stall) begin
          w_retire     = 1'b1;
          w_next_state = S_REQ;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Next-PC select: jump beats a taken branch beats sequential.
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

  always_comb begin
    w_next_pc = w_pc_plus4;
    if (j)                w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
    else if (branch && zero) w_next_pc = w_pc_plus4 + w_br_off;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_instr <= 32'd0;
    end else begin
      if (w_load)   r_instr <= imem_rdata;
      if (w_retire) r_pc    <= w_next_pc;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_count, r_stall_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_count <= 32'd0;
      r_stall_count <= 32'd0;
    end else begin
      if (w_retire) r_fetch_count <= r_fetch_count + 32'd1;
      if ((r_state == S_VALID && stall) || (r_state == S_REQ && !imem_ack))
        r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;
`endif

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign pc_plus4  = w_pc_plus4;
  assign instr     = r_instr;
  assign opcode    = r_instr[31:26];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: three instances (RESET_PC = 0, FFFF_FFFC, 1000_0000)
// share stimulus; only the one under test is out of reset at any time.
// Inputs are driven and outputs sampled on the falling edge.

module tb_fetch_unit;

  localparam logic [2:0][31:0] RPC = {32'h1000_0000, 32'hFFFF_FFFC, 32'h0000_0000};

  logic        clk = 1'b0;
  logic [2:0]  rst_v;
  logic        ack, stall, br, jj, z;
  logic [31:0] rdata;

  logic        o_req [3];
  logic        o_vld [3];
  logic [31:0] o_addr [3];
  logic [31:0] o_instr [3];
  logic [5:0]  o_op [3];
  logic [31:0] o_pc [3];
  logic [31:0] o_pp4 [3];
`ifdef FETCH_PERF_EN
  logic [31:0] o_fcnt [3];
  logic [31:0] o_scnt [3];
`endif

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      fetch_unit #(.RESET_PC(RPC[g])) u_dut (
        .clk         (clk),
        .rst         (rst_v[g]),
        .imem_req    (o_req[g]),
        .imem_addr   (o_addr[g]),
        .imem_ack    (ack),
        .imem_rdata  (rdata),
        .instr       (o_instr[g]),
        .opcode      (o_op[g]),
        .instr_valid (o_vld[g]),
        .stall       (stall),
        .branch      (br),
        .j           (jj),
        .zero        (z),
        .pc          (o_pc[g]),
        .pc_plus4    (o_pp4[g])
`ifdef FETCH_PERF_EN
        ,
        .fetch_count (o_fcnt[g]),
        .stall_count (o_scnt[g])
`endif
      );
    end
  endgenerate

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        stall, br, jj, z;
    logic        e_req, e_vld;
    logic [31:0] e_pc, e_instr;
  } vec_t;

  vec_t tv [32];
  int   ntests = 0;
  int   nfail  = 0;

  function automatic vec_t mk(logic a, logic [31:0] rd, logic s, logic b, logic jp, logic zf,
                              logic er, logic ev, logic [31:0] ep, logic [31:0] ei);
    vec_t v;
    v.ack = a; v.rdata = rd; v.stall = s; v.br = b; v.jj = jp; v.z = zf;
    v.e_req = er; v.e_vld = ev; v.e_pc = ep; v.e_instr = ei;
    return v;
  endfunction

  task automatic check_state(int d, string tag, logic er, logic ev,
                             logic [31:0] ep, logic [31:0] ei);
    logic [31:0] epp4;
    logic [5:0]  eop;
    epp4 = ep + 32'd4;
    eop  = ei[31:26];
    ntests++;
    if (o_req[d] !== er || o_vld[d] !== ev || o_addr[d] !== ep || o_pc[d] !== ep ||
        o_pp4[d] !== epp4 || o_instr[d] !== ei || o_op[d] !== eop) begin
      nfail++;
      $display("FAIL %s dut%0d: got req=%b vld=%b addr=%h pc=%h pc4=%h instr=%h op=%b; want req=%b vld=%b pc=%h pc4=%h instr=%h op=%b",
               tag, d, o_req[d], o_vld[d], o_addr[d], o_pc[d], o_pp4[d], o_instr[d], o_op[d],
               er, ev, ep, epp4, ei, eop);
    end
  endtask

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] want);
    ntests++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic run_rows(int d, int lo, int hi);
    for (int i = lo; i <= hi; i++) begin
      ack = tv[i].ack; rdata = tv[i].rdata; stall = tv[i].stall;
      br = tv[i].br; jj = tv[i].jj; z = tv[i].z;
      @(posedge clk);
      @(negedge clk);
      check_state(d, $sformatf("row%0d", i), tv[i].e_req, tv[i].e_vld, tv[i].e_pc, tv[i].e_instr);
    end
    ack = 1'b0; stall = 1'b0; br = 1'b0; jj = 1'b0; z = 1'b0; rdata = 32'd0;
  endtask

  // Release one instance from reset and step it into S_REQ.
  task automatic bring_up(int d, logic [31:0] rpc);
    rst_v = 3'b111;
    @(negedge clk);
    rst_v[d] = 1'b0;
    #1;
    check_state(d, "release", 1'b0, 1'b0, rpc, 32'd0);
    @(negedge clk);
    check_state(d, "first_req", 1'b1, 1'b0, rpc, 32'd0);
  endtask

  initial begin
    // dut0, RESET_PC = 0: sequential, branch, jump, stall
    //            ack rdata          stl br j  z   req vld pc            instr
    tv[0]  = mk(1, 32'h8C01_0004, 1, 0, 0, 0,  0, 1, 32'h0000_0000, 32'h8C01_0004);
    tv[1]  = mk(0, 32'h0,         0, 0, 0, 0,  1, 0, 32'h0000_0004, 32'h8C01_0004);
    tv[2]  = mk(1, 32'h0,         1, 0, 0, 0,  0, 1, 32'h0000_0004, 32'h0);
    tv[3]  = mk(0, 32'h0,         0, 0, 0, 0,  1, 0, 32'h0000_0008, 32'h0);
    tv[4]  = mk(1, 32'h1000_0003, 1, 0, 0, 0,  0, 1, 32'h0000_0008, 32'h1000_0003);
    tv[5]  = mk(0, 32'h0,         0, 1, 0, 0,  1, 0, 32'h0000_000C, 32'h1000_0003); // not taken
    tv[6]  = mk(0, 32'h0,         0, 0, 0, 0,  1, 0, 32'h0000_000C, 32'h1000_0003); // wait state
    tv[7]  = mk(1, 32'h0800_0002, 1, 0, 0, 0,  0, 1, 32'h0000_000C, 32'h0800_0002);
    tv[8]  = mk(0, 32'h0,         0, 0, 1, 0,  1, 0, 32'h0000_0008, 32'h0800_0002); // j back to 8
    tv[9]  = mk(1, 32'h1000_0003, 1, 0, 0, 0,  0, 1, 32'h0000_0008, 32'h1000_0003);
    tv[10] = mk(0, 32'h0,         0, 1, 0, 1,  1, 0, 32'h0000_0018, 32'h1000_0003); // taken +3
    tv[11] = mk(1, 32'h1000_0001, 0, 0, 0, 0,  0, 1, 32'h0000_0018, 32'h1000_0001);
    tv[12] = mk(0, 32'h0,         0, 1, 0, 1,  1, 0, 32'h0000_0020, 32'h1000_0001);
    tv[13] = mk(1, 32'h1000_FFFF, 1, 0, 0, 0,  0, 1, 32'h0000_0020, 32'h1000_FFFF);
    tv[14] = mk(0, 32'h0,         0, 1, 0, 1,  1, 0, 32'h0000_0020, 32'h1000_FFFF); // offset -1
    tv[15] = mk(1, 32'hAC02_0008, 1, 0, 0, 0,  0, 1, 32'h0000_0020, 32'hAC02_0008);
    tv[16] = mk(1, 32'hDEAD_BEEF, 1, 1, 0, 1,  0, 1, 32'h0000_0020, 32'hAC02_0008); // stall, stray ack
    tv[17] = mk(0, 32'hDEAD_BEEF, 1, 1, 0, 1,  0, 1, 32'h0000_0020, 32'hAC02_0008);
    tv[18] = mk(1, 32'hDEAD_BEEF, 1, 0, 1, 0,  0, 1, 32'h0000_0020, 32'hAC02_0008);
    tv[19] = mk(0, 32'hDEAD_BEEF, 1, 0, 0, 0,  0, 1, 32'h0000_0020, 32'hAC02_0008);
    tv[20] = mk(1, 32'hDEAD_BEEF, 1, 0, 0, 0,  0, 1, 32'h0000_0020, 32'hAC02_0008);
    tv[21] = mk(0, 32'h0,         0, 0, 0, 0,  1, 0, 32'h0000_0024, 32'hAC02_0008); // one retire
    tv[22] = mk(0, 32'h0,         0, 0, 0, 0,  1, 0, 32'h0000_0024, 32'hAC02_0008);
    tv[23] = mk(1, 32'h0,         1, 0, 0, 0,  0, 1, 32'h0000_0024, 32'h0);
    // dut1, RESET_PC = FFFF_FFFC: three wait states then wrap to 0
    tv[24] = mk(0, 32'h0,         0, 0, 0, 0,  1, 0, 32'hFFFF_FFFC, 32'h0);
    tv[25] = mk(0, 32'h0,         0, 0, 0, 0,  1, 0, 32'hFFFF_FFFC, 32'h0);
    tv[26] = mk(0, 32'h0,         0, 0, 0, 0,  1, 0, 32'hFFFF_FFFC, 32'h0);
    tv[27] = mk(1, 32'h2001_0005, 1, 0, 0, 0,  0, 1, 32'hFFFF_FFFC, 32'h2001_0005);
    tv[28] = mk(0, 32'h0,         0, 0, 0, 0,  1, 0, 32'h0000_0000, 32'h2001_0005);
    // dut2, RESET_PC = 1000_0000: jump wins over taken branch
    tv[29] = mk(1, 32'h0800_0010, 1, 0, 0, 0,  0, 1, 32'h1000_0000, 32'h0800_0010);
    tv[30] = mk(0, 32'h0,         0, 1, 1, 1,  1, 0, 32'h1000_0040, 32'h0800_0010);
    tv[31] = mk(0, 32'h0,         0, 0, 0, 0,  1, 0, 32'h1000_0040, 32'h0800_0010);

    rst_v = 3'b111;
    ack = 1'b0; rdata = 32'd0; stall = 1'b0; br = 1'b0; jj = 1'b0; z = 1'b0;

    // Reset held 3 cycles with a pending ack: nothing may move.
    ack = 1'b1; rdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    check_state(0, "in_reset", 1'b0, 1'b0, 32'h0, 32'h0);
    ack = 1'b0; rdata = 32'd0;

    bring_up(0, 32'h0);
    run_rows(0, 0, 23);

    bring_up(1, 32'hFFFF_FFFC);
    run_rows(1, 24, 28);
`ifdef FETCH_PERF_EN
    check_val("dut1_fetch_count", o_fcnt[1], 32'd1);
    check_val("dut1_stall_count", o_scnt[1], 32'd3);
`endif

    bring_up(2, 32'h1000_0000);
    run_rows(2, 29, 31);
`ifdef FETCH_PERF_EN
    check_val("dut2_fetch_count", o_fcnt[2], 32'd1);
    check_val("dut2_stall_count", o_scnt[2], 32'd1);
`endif

    // Async reset between edges while in S_REQ: outputs clear with no edge.
    #2 rst_v[2] = 1'b1;
    #1;
    check_state(2, "async_rst", 1'b0, 1'b0, 32'h1000_0000, 32'h0);
`ifdef FETCH_PERF_EN
    check_val("rst_fetch_count", o_fcnt[2], 32'd0);
    check_val("rst_stall_count", o_scnt[2], 32'd0);
`endif

    // Late ack after release lands in S_IDLE and must be ignored.
    @(negedge clk);
    rst_v[2] = 1'b0;
    ack = 1'b1; rdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    check_state(2, "late_ack", 1'b1, 1'b0, 32'h1000_0000, 32'h0);
    ack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
